cpu_clock_ctrl: RTL and testbench
=================================

Name: cpu_clock_ctrl

Overview:
- Upstream stage of the board top level. Produces the clock/step/reset controls that the processor, LEDG indicators and displays consume.
- Takes the 28 MHz board clock, the raw active-low KEY buttons and the mode/rate switches. Outputs:
  - a divided automatic clock;
  - a debounced manual step;
  - a debounced reset;
  - a glitch-free registered selected CPU clock, plus a one-cycle tick.
- Replaces the open combinational clock mux at top level.

Parameters:
- DEBOUNCE_CYCLES, 280000, consecutive stable cycles needed to accept a key change (10 ms at 28 MHz).
- AUTO_DIV, 14000000, half-period of the automatic clock at rate 0, in clk cycles (1 Hz).
- CNT_W, 24, width of the divider counter; must hold AUTO_DIV-1.
- DB_W, 19, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk, input, 1: board clock (CLK_28).
- rst, input, 1: synchronous, active-high reset.
- key_step_n, input, 1: raw step button, active-low, asynchronous to clk.
- key_rst_n, input, 1: raw reset button, active-low, asynchronous to clk.
- sw_modo, input, 1: 0 = automatic clock, 1 = manual step. Raw switch.
- sw_rate, input, 2: automatic rate select. Raw switches.
- clk_auto, output, 1: free-running divided square wave (LEDG[0]).
- bt_step, output, 1: debounced step level, 1 = pressed (LEDG[1]).
- bt_rst, output, 1: debounced reset level, 1 = pressed (LEDG[2]).
- clk_cpu, output, 1: registered selected CPU clock.
- cpu_tick, output, 1: one-cycle pulse, one cycle after each clk_cpu rising edge.
- rst_cpu, output, 1: registered reset to the processor, equal to rst OR bt_rst.

Behaviour:
- Clocking and reset: one clock, clk; reset synchronous, active-high.
- Reset state:
  - all outputs 0, except rst_cpu = 1 during rst;
  - counters 0;
  - synchronizer flops load "released" (1) for keys and 0 for switches.
- Synchronization: key_step_n, key_rst_n, sw_modo and sw_rate pass through 2-FF synchronizers before any use. The sw_rate bits are synchronized independently, and the next two cycles use whatever value they present.
- Debounce (per key, on the inverted synchronized level):
  - keep a stable state and a counter;
  - if the sample equals the stable state, the counter clears;
  - otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the stable state flips and the counter clears;
  - a bounce shorter than DEBOUNCE_CYCLES cycles never changes the output;
  - latency from pin edge to bt_* change = 2 + DEBOUNCE_CYCLES cycles.
- Auto divider:
  - terminal count T = (AUTO_DIV >> (2*rate)) - 1, so rate 0/1/2/3 gives 1/4/16/64 Hz;
  - when cnt >= T: cnt becomes 0 and clk_auto toggles; otherwise cnt increments;
  - using >= makes a rate change to a faster setting wrap on the next cycle, never run to overflow;
  - the divider runs in both modes.
- Mode select, registered:
  - clk_cpu <= (modo_sync == MODE_STEP) ? bt_step : clk_auto;
  - a mode change takes effect on the cycle after modo_sync changes;
  - a resulting 0->1 on clk_cpu counts as a real edge, which is accepted.
- cpu_tick <= clk_cpu & ~clk_cpu_q (registered edge detect). It is exactly one cycle wide and pulses only on clk_cpu rising edges.
- In step mode, one debounced press gives exactly one clk_cpu rising edge and one cpu_tick. clk_cpu stays high while the key is held.
- rst_cpu is registered. Pressing reset mid-run does not stop the divider, and clk_cpu keeps toggling. The processor ignores clk_cpu while rst_cpu = 1.
- Asserting rst mid-operation clears everything on the next edge, including the debounce state. A key still held after rst deasserts must debounce again before it is seen.

Decomposition:
- Package cpu_clock_pkg:
  - MODE_AUTO = 1'b0, MODE_STEP = 1'b1;
  - rate encodings RATE_1HZ .. RATE_64HZ;
  - default values for DEBOUNCE_CYCLES and AUTO_DIV.
- Sub-module key_debounce:
  - contains the synchronizer, counter and stable state, with parameters DEBOUNCE_CYCLES and DB_W;
  - instantiated twice, once for step and once for reset.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES = 4, AUTO_DIV = 8.
- Reset: hold rst for 3 cycles. All outputs are 0 and rst_cpu = 1 during rst. rst_cpu falls the cycle after rst drops.
- Auto rate 0, sw_modo = 0, run 64 cycles:
  - clk_auto toggles every 8 cycles;
  - clk_cpu follows it with 1 cycle of delay;
  - cpu_tick fires once per 16 cycles;
  - change to rate 1 mid-count while cnt = 5: the next toggle occurs 3 synchronizer/compare cycles later, and the period thereafter is 4 cycles.
- Bounce rejection, sw_modo = 1: pulse key_step_n low for 3 cycles, high for 1, low for 3. bt_step stays 0 and no cpu_tick occurs.
- Step press: hold key_step_n low for 20 cycles. bt_step rises 6 cycles after the pin edge, clk_cpu rises 1 cycle later, and exactly one cpu_tick occurs. On release, bt_step falls 6 cycles after the pin edge with no tick.
- Reset key: hold key_rst_n low for 10 cycles. rst_cpu rises 7 cycles after the pin edge. Assert rst during the hold: bt_rst clears, then after rst deasserts it re-asserts after 6 more cycles.
- Mode switch while clk_auto = 1 and bt_step = 0: set sw_modo = 1. clk_cpu falls 3 cycles later, with no spurious cpu_tick.

Source files
------------

// File: rtl/cpu_clock_pkg.sv
// Shared constants for the CPU clock controller: mode/rate encodings, default timing
// and the auto-divider terminal count helper.
package cpu_clock_pkg;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  typedef enum logic [1:0] {
    RATE_1HZ  = 2'd0,
    RATE_4HZ  = 2'd1,
    RATE_16HZ = 2'd2,
    RATE_64HZ = 2'd3
  } rate_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 280000;
  localparam int unsigned DEFAULT_AUTO_DIV        = 14000000;

  // Each rate step is 4x faster; a half-period that shifts down to zero clamps to wrap every cycle.
  function automatic int unsigned auto_terminal(int unsigned div, rate_e rate);
    logic [2:0]  shamt;
    int unsigned half;
    shamt = {rate, 1'b0};
    half  = div >> shamt;
    return (half == 0) ? 0 : half - 1;
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Board-facing bundle of the CPU clock controller: raw keys/switches in, CPU controls out.
interface cpu_clock_ctrl_if;

  logic       key_step_n;
  logic       key_rst_n;
  logic       sw_modo;
  logic [1:0] sw_rate;
  logic       clk_auto;
  logic       bt_step;
  logic       bt_rst;
  logic       clk_cpu;
  logic       cpu_tick;
  logic       rst_cpu;

  modport master (
    output key_step_n, key_rst_n, sw_modo, sw_rate,
    input  clk_auto, bt_step, bt_rst, clk_cpu, cpu_tick, rst_cpu
  );

  modport slave (
    input  key_step_n, key_rst_n, sw_modo, sw_rate,
    output clk_auto, bt_step, bt_rst, clk_cpu, cpu_tick, rst_cpu
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low key and accepts a level change only after it has held
// steady for DEBOUNCE_CYCLES consecutive samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = cpu_clock_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned DB_W            = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed
);

  localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_n};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sample = ~sync_q[1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sample != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pressed = stable_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Generates the processor clock/step/reset controls from the board clock, keys and switches;
// the selected CPU clock is registered so mode changes never glitch.
module cpu_clock_ctrl
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned AUTO_DIV        = DEFAULT_AUTO_DIV,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned DB_W            = 19
) (
  input logic              clk,
  input logic              rst,
  cpu_clock_ctrl_if.slave  bus
);

  logic             bt_step, bt_rst;
  logic [1:0]       modo_q;
  rate_e            rate_s1_q, rate_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, term;
  logic             clk_auto_q, clk_auto_d;
  logic             clk_cpu_q, clk_cpu_d;
  logic             clk_cpu_dly_q;
  logic             tick_q;
  logic             rst_cpu_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_step (
    .clk    (clk),
    .rst    (rst),
    .key_n  (bus.key_step_n),
    .pressed(bt_step)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_rst (
    .clk    (clk),
    .rst    (rst),
    .key_n  (bus.key_rst_n),
    .pressed(bt_rst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      modo_q        <= 2'b00;
      rate_s1_q     <= RATE_1HZ;
      rate_s2_q     <= RATE_1HZ;
      cnt_q         <= '0;
      clk_auto_q    <= 1'b0;
      clk_cpu_q     <= 1'b0;
      clk_cpu_dly_q <= 1'b0;
      tick_q        <= 1'b0;
      rst_cpu_q     <= 1'b1;
    end else begin
      modo_q        <= {modo_q[0], bus.sw_modo};
      rate_s1_q     <= rate_e'(bus.sw_rate);
      rate_s2_q     <= rate_s1_q;
      cnt_q         <= cnt_d;
      clk_auto_q    <= clk_auto_d;
      clk_cpu_q     <= clk_cpu_d;
      clk_cpu_dly_q <= clk_cpu_q;
      tick_q        <= clk_cpu_q & ~clk_cpu_dly_q;
      rst_cpu_q     <= bt_rst;
    end
  end

  // Compare with >= so a switch to a faster rate wraps at once instead of counting to overflow.
  always_comb begin
    term       = CNT_W'(auto_terminal(AUTO_DIV, rate_s2_q));
    cnt_d      = cnt_q + 1'b1;
    clk_auto_d = clk_auto_q;
    if (cnt_q >= term) begin
      cnt_d      = '0;
      clk_auto_d = ~clk_auto_q;
    end
  end

  always_comb begin
    clk_cpu_d = (modo_q[1] == MODE_STEP) ? bt_step : clk_auto_q;
  end

  assign bus.clk_auto = clk_auto_q;
  assign bus.bt_step  = bt_step;
  assign bus.bt_rst   = bt_rst;
  assign bus.clk_cpu  = clk_cpu_q;
  assign bus.cpu_tick = tick_q;
  assign bus.rst_cpu  = rst_cpu_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: output changes are logged with cycle stamps and matched
// against an expected-event queue filled as each stimulus step is applied.
module tb_cpu_clock_ctrl;

  localparam int K_AUTO   = 0;
  localparam int K_CPU_R  = 1;
  localparam int K_CPU_F  = 2;
  localparam int K_TICK   = 3;
  localparam int K_STEP_R = 4;
  localparam int K_STEP_F = 5;
  localparam int K_RST_R  = 6;
  localparam int K_RST_F  = 7;
  localparam int K_RCPU_R = 8;
  localparam int K_RCPU_F = 9;

  typedef struct packed {
    logic [7:0]  kind;
    logic [31:0] at;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [9:0] watch;
  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic       p_auto, p_cpu, p_step, p_rst, p_rcpu;

  cpu_clock_ctrl_if bus ();

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV       (8),
    .CNT_W          (24),
    .DB_W           (19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    watch  = '0;
    p_auto = 1'b0;
    p_cpu  = 1'b0;
    p_step = 1'b0;
    p_rst  = 1'b0;
    p_rcpu = 1'b0;
  end

  task automatic rec(input int k, input logic cond);
    if (cond && watch[k]) obs_q.push_back(ev_t'{kind: 8'(k), at: 32'(cyc)});
  endtask

  // Stamp = number of rising edges so far, i.e. the edge that produced the change.
  always @(posedge clk) begin
    #1;
    rec(K_AUTO, bus.clk_auto !== p_auto);
    rec(K_CPU_R, bus.clk_cpu === 1'b1 && p_cpu === 1'b0);
    rec(K_CPU_F, bus.clk_cpu === 1'b0 && p_cpu === 1'b1);
    rec(K_TICK, bus.cpu_tick !== 1'b0);
    rec(K_STEP_R, bus.bt_step === 1'b1 && p_step === 1'b0);
    rec(K_STEP_F, bus.bt_step === 1'b0 && p_step === 1'b1);
    rec(K_RST_R, bus.bt_rst === 1'b1 && p_rst === 1'b0);
    rec(K_RST_F, bus.bt_rst === 1'b0 && p_rst === 1'b1);
    rec(K_RCPU_R, bus.rst_cpu === 1'b1 && p_rcpu === 1'b0);
    rec(K_RCPU_F, bus.rst_cpu === 1'b0 && p_rcpu === 1'b1);
    p_auto = bus.clk_auto;
    p_cpu  = bus.clk_cpu;
    p_step = bus.bt_step;
    p_rst  = bus.bt_rst;
    p_rcpu = bus.rst_cpu;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic watch_start(input logic [9:0] mask);
    obs_q.delete();
    exp_q.delete();
    watch = mask;
  endtask

  task automatic expect_ev(input int k, input int c);
    exp_q.push_back(ev_t'{kind: 8'(k), at: 32'(c)});
  endtask

  task automatic check_events(input string tag);
    ev_t e;
    int  idx;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = -1;
      foreach (obs_q[i]) if (idx < 0 && obs_q[i] === e) idx = i;
      n_cmp++;
      assert (idx >= 0)
      else begin
        n_err++;
        $error("FAIL %s: observed no event, expected kind %0d at cycle %0d", tag, e.kind, e.at);
      end
      if (idx >= 0) obs_q.delete(idx);
    end
    n_cmp++;
    assert (obs_q.size() === 0)
    else begin
      n_err++;
      $error("FAIL %s_extra: observed %0d extra events (first kind %0d at cycle %0d), expected 0",
             tag, obs_q.size(), obs_q[0].kind, obs_q[0].at);
    end
    watch = '0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    bus.key_step_n = 1'b1;
    bus.key_rst_n  = 1'b1;
    bus.sw_modo    = 1'b0;
    bus.sw_rate    = 2'd0;

    // Reset held for three edges.
    wait_until(3);
    chk("rst_clk_auto", 32'(bus.clk_auto), 32'd0);
    chk("rst_bt_step", 32'(bus.bt_step), 32'd0);
    chk("rst_bt_rst", 32'(bus.bt_rst), 32'd0);
    chk("rst_clk_cpu", 32'(bus.clk_cpu), 32'd0);
    chk("rst_cpu_tick", 32'(bus.cpu_tick), 32'd0);
    chk("rst_rst_cpu", 32'(bus.rst_cpu), 32'd1);
    rst = 1'b0;
    wait_until(4);
    chk("rst_cpu_release", 32'(bus.rst_cpu), 32'd0);

    // Auto mode, rate 0: toggle every 8 edges, clk_cpu one edge behind, tick one after its rise.
    watch_start(10'((1 << K_AUTO) | (1 << K_CPU_R) | (1 << K_CPU_F) | (1 << K_TICK)));
    for (int k = 0; k < 8; k++) expect_ev(K_AUTO, 11 + 8 * k);
    for (int k = 0; k < 4; k++) begin
      expect_ev(K_CPU_R, 12 + 16 * k);
      expect_ev(K_CPU_F, 20 + 16 * k);
      expect_ev(K_TICK, 13 + 16 * k);
    end
    wait_until(70);
    check_events("auto_rate0");

    // Switch to step mode while clk_cpu is high: one clean fall, no tick.
    wait_until(77);
    chk("mode_pre_auto_hi", 32'(bus.clk_auto), 32'd1);
    watch_start(10'((1 << K_CPU_R) | (1 << K_CPU_F) | (1 << K_TICK)));
    bus.sw_modo = 1'b1;
    expect_ev(K_CPU_F, 80);
    wait_until(86);
    check_events("mode_switch");

    // Divider keeps running in step mode; rate 1 applied with cnt = 5.
    wait_until(88);
    watch_start(10'((1 << K_AUTO) | (1 << K_CPU_R) | (1 << K_TICK)));
    bus.sw_rate = 2'd1;
    for (int k = 0; k < 5; k++) expect_ev(K_AUTO, 91 + 2 * k);
    wait_until(100);
    check_events("rate_change");

    // Bounce: 3 low, 1 high, 3 low never reaches the 4-sample threshold.
    watch_start(10'((1 << K_STEP_R) | (1 << K_STEP_F) | (1 << K_TICK) | (1 << K_CPU_R)));
    bus.key_step_n = 1'b0;
    wait_until(103);
    bus.key_step_n = 1'b1;
    wait_until(104);
    bus.key_step_n = 1'b0;
    wait_until(107);
    bus.key_step_n = 1'b1;
    wait_until(120);
    chk("bounce_bt_step", 32'(bus.bt_step), 32'd0);
    check_events("bounce");

    // Step press held for 20 cycles: one rise, one tick, clk_cpu held high.
    watch_start(10'((1 << K_STEP_R) | (1 << K_STEP_F) | (1 << K_TICK) | (1 << K_CPU_R) |
                    (1 << K_CPU_F)));
    bus.key_step_n = 1'b0;
    expect_ev(K_STEP_R, 126);
    expect_ev(K_CPU_R, 127);
    expect_ev(K_TICK, 128);
    wait_until(135);
    chk("step_held_clk_cpu", 32'(bus.clk_cpu), 32'd1);
    chk("step_held_bt_step", 32'(bus.bt_step), 32'd1);
    wait_until(140);
    bus.key_step_n = 1'b1;
    expect_ev(K_STEP_F, 146);
    expect_ev(K_CPU_F, 147);
    wait_until(160);
    check_events("step_press");

    // Reset key, interrupted by rst while held; it must debounce again afterwards.
    watch_start(10'((1 << K_RST_R) | (1 << K_RST_F) | (1 << K_RCPU_R) | (1 << K_RCPU_F)));
    bus.key_rst_n = 1'b0;
    expect_ev(K_RST_R, 166);
    expect_ev(K_RCPU_R, 167);
    wait_until(170);
    rst = 1'b1;
    expect_ev(K_RST_F, 171);
    wait_until(172);
    chk("midrst_clk_auto", 32'(bus.clk_auto), 32'd0);
    chk("midrst_clk_cpu", 32'(bus.clk_cpu), 32'd0);
    chk("midrst_bt_rst", 32'(bus.bt_rst), 32'd0);
    chk("midrst_rst_cpu", 32'(bus.rst_cpu), 32'd1);
    chk("midrst_cpu_tick", 32'(bus.cpu_tick), 32'd0);
    rst = 1'b0;
    expect_ev(K_RCPU_F, 173);
    expect_ev(K_RST_R, 178);
    expect_ev(K_RCPU_R, 179);
    wait_until(185);
    bus.key_rst_n = 1'b1;
    expect_ev(K_RST_F, 191);
    expect_ev(K_RCPU_F, 192);
    wait_until(200);
    check_events("rst_key");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
